// File: rtl/ex6_meter.sv
// Metered ex6 ten-state Mealy controller: registered outputs plus an activation counter
// that blanks (MODE 0) or locks out in s1 (MODE 1) once the licensed budget is spent.
module ex6_meter #(
  parameter int unsigned      LIMIT = 4,
  parameter int unsigned      CNT_W = 8,
  parameter int unsigned      KEY_W = 8,
  parameter logic [KEY_W-1:0] KEY   = 8'hA5,
  parameter bit               MODE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x1,
  input  logic             x2,
  input  logic             x3,
  input  logic             x4,
  input  logic             x5,
  input  logic             key_vld,
  input  logic [KEY_W-1:0] key,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic             y4,
  output logic             y5,
  output logic             y6,
  output logic             y7,
  output logic             y8,
  output logic             metered,
  output logic [CNT_W-1:0] act_cnt
);

  typedef enum logic [3:0] {
    S1  = 4'd0,
    S2  = 4'd1,
    S3  = 4'd2,
    S4  = 4'd3,
    S5  = 4'd4,
    S6  = 4'd5,
    S7  = 4'd6,
    S8  = 4'd7,
    S9  = 4'd8,
    S10 = 4'd9
  } state_t;

  // Output words, bit n-1 drives y<n>.
  localparam logic [7:0] Y_NONE = 8'b0000_0000;
  localparam logic [7:0] Y_A    = 8'b0001_1101;
  localparam logic [7:0] Y_B    = 8'b0001_0100;
  localparam logic [7:0] Y_C    = 8'b0000_0011;
  localparam logic [7:0] Y_D    = 8'b1010_0100;
  localparam logic [7:0] Y_E    = 8'b0111_0000;
  localparam logic [7:0] Y_F    = 8'b0010_0001;
  localparam logic [7:0] Y_124  = 8'b0000_1011;
  localparam logic [7:0] Y_3468 = 8'b1010_1100;
  localparam logic [7:0] Y_345  = 8'b0001_1100;
  localparam logic [7:0] Y_8    = 8'b1000_0000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_t           tbl_state;
  logic [7:0]       tbl_y;
  logic             activation;
  logic             over_budget;

  // Unmetered ex6 transition/output table.
  always_comb begin
    tbl_state = S1;
    tbl_y     = Y_NONE;
    case (state_q)
      S1: begin
        case ({x1, x2})
          2'b11:   begin tbl_state = S2; tbl_y = Y_A;    end
          2'b10:   begin tbl_state = S3; tbl_y = Y_B;    end
          2'b01:   begin tbl_state = S1; tbl_y = Y_NONE; end
          default: begin tbl_state = S4; tbl_y = Y_C;    end
        endcase
      end
      S2: begin
        case ({x1, x2})
          2'b11:   begin tbl_state = S2; tbl_y = Y_A;    end
          2'b01:   begin tbl_state = S5; tbl_y = Y_124;  end
          2'b10:   begin tbl_state = S3; tbl_y = Y_3468; end
          default: begin tbl_state = S4; tbl_y = Y_345;  end
        endcase
      end
      S3: begin
        if (x3) begin
          tbl_state = S6; tbl_y = Y_B;
        end else begin
          case ({x1, x2})
            2'b11:   begin tbl_state = S2; tbl_y = Y_A; end
            2'b10:   begin tbl_state = S3; tbl_y = Y_B; end
            2'b01:   begin tbl_state = S5; tbl_y = Y_D; end
            default: begin tbl_state = S4; tbl_y = Y_C; end
          endcase
        end
      end
      S4: begin
        if (x3) begin
          tbl_state = S7; tbl_y = Y_E;
        end else if (x1 && x2) begin
          tbl_state = S2; tbl_y = Y_A;
        end else if (x1) begin
          tbl_state = S3; tbl_y = Y_B;
        end else begin
          tbl_state = S4; tbl_y = Y_C;
        end
      end
      S5: begin
        // Every s5 output word also carries y8.
        if (x5) begin
          tbl_state = S4; tbl_y = Y_C | Y_8;
        end else begin
          case ({x1, x2})
            2'b11:   begin tbl_state = S8; tbl_y = Y_A | Y_8; end
            2'b01:   begin tbl_state = S5; tbl_y = Y_D | Y_8; end
            2'b10:   begin tbl_state = S9; tbl_y = Y_B | Y_8; end
            default: begin tbl_state = S4; tbl_y = Y_C | Y_8; end
          endcase
        end
      end
      S6: begin
        if (!x3) begin
          tbl_state = S4; tbl_y = Y_C;
        end else begin
          case ({x1, x2})
            2'b11:   begin tbl_state = S2; tbl_y = Y_A; end
            2'b10:   begin tbl_state = S6; tbl_y = Y_B; end
            2'b01:   begin tbl_state = S5; tbl_y = Y_D; end
            default: begin tbl_state = S4; tbl_y = Y_C; end
          endcase
        end
      end
      S7: begin
        if (!x3) begin
          tbl_state = S4; tbl_y = Y_C;
        end else if (x1 || x4) begin
          tbl_state = S10; tbl_y = Y_F;
        end else begin
          tbl_state = S7; tbl_y = Y_E;
        end
      end
      S8: begin
        tbl_state = S2; tbl_y = Y_A;
      end
      S9: begin
        tbl_state = S3; tbl_y = Y_B;
      end
      S10: begin
        if (!x3) begin
          tbl_state = S4; tbl_y = Y_C;
        end else if (x1 && x2) begin
          tbl_state = S2; tbl_y = Y_A;
        end else if (x1) begin
          tbl_state = S6; tbl_y = Y_B;
        end else begin
          tbl_state = S1; tbl_y = Y_F;
        end
      end
      default: begin
        tbl_state = S1; tbl_y = Y_NONE;
      end
    endcase
  end

  // Budget is judged on the count before this edge's increment.
  assign activation  = (state_q == S1) && !(!x1 && x2);
  assign over_budget = activation && (cnt_q >= LIMIT_C);

  // Apply metering to the table result.
  always_comb begin
    state_d = tbl_state;
    y_d     = tbl_y;
    if (over_budget) begin
      y_d = Y_NONE;
      if (MODE) begin
        state_d = S1;
      end else begin
        state_d = tbl_state;
      end
    end else begin
      y_d = tbl_y;
    end
  end

  // Counter: a key event overrides the activation increment.
  always_comb begin
    cnt_d = cnt_q;
    if (key_vld) begin
      if (key == KEY) begin
        cnt_d = '0;
      end else begin
        cnt_d = CNT_MAX;
      end
    end else if (activation && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, output and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S1;
      y_q     <= Y_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {y8, y7, y6, y5, y4, y3, y2, y1} = y_q;
  assign act_cnt = cnt_q;
  assign metered = (cnt_q >= LIMIT_C);

endmodule

// File: tb/tb_ex6_meter.sv
// Scoreboard bench for ex6_meter: one MODE 0 and one MODE 1 instance share stimulus and are
// checked every cycle against a behavioural model, plus a few fixed-value checkpoints.
module tb_ex6_meter;

  localparam int         LIMIT = 4;
  localparam logic [7:0] KEY   = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] x;
  logic       key_vld;
  logic [7:0] key;
  logic [7:0] ya, yb, cnta, cntb;
  logic       meta, metb;

  always #5 clk = ~clk;

  ex6_meter #(.LIMIT(4), .CNT_W(8), .KEY_W(8), .KEY(8'hA5), .MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .x1(x[0]), .x2(x[1]), .x3(x[2]), .x4(x[3]), .x5(x[4]),
    .key_vld(key_vld), .key(key),
    .y1(ya[0]), .y2(ya[1]), .y3(ya[2]), .y4(ya[3]), .y5(ya[4]), .y6(ya[5]), .y7(ya[6]), .y8(ya[7]),
    .metered(meta), .act_cnt(cnta));

  ex6_meter #(.LIMIT(4), .CNT_W(8), .KEY_W(8), .KEY(8'hA5), .MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .x1(x[0]), .x2(x[1]), .x3(x[2]), .x4(x[3]), .x5(x[4]),
    .key_vld(key_vld), .key(key),
    .y1(yb[0]), .y2(yb[1]), .y3(yb[2]), .y4(yb[3]), .y5(yb[4]), .y6(yb[5]), .y7(yb[6]), .y8(yb[7]),
    .metered(metb), .act_cnt(cntb));

  typedef struct {
    logic [7:0] y0; logic [7:0] c0; logic m0;
    logic [7:0] y1; logic [7:0] c1; logic m1;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_st[2];
  int   m_cnt[2];

  function automatic logic [7:0] yb_of(input int n);
    logic [7:0] one;
    one = 8'd1;
    return one << (n - 1);
  endfunction

  function automatic logic [4:0] mkx(input bit a, input bit b, input bit c, input bit d, input bit e);
    return {e, d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ex6 behaviour for one state visit, written from the transition list.
  task automatic model_trans(input int st, input logic [4:0] xv, output int nst, output logic [7:0] yv);
    bit a, b, c, d, e;
    logic [7:0] ga, gb, gc, gd, ge, gf;
    a = xv[0]; b = xv[1]; c = xv[2]; d = xv[3]; e = xv[4];
    ga = yb_of(1) | yb_of(3) | yb_of(4) | yb_of(5);
    gb = yb_of(3) | yb_of(5);
    gc = yb_of(1) | yb_of(2);
    gd = yb_of(3) | yb_of(6) | yb_of(8);
    ge = yb_of(5) | yb_of(6) | yb_of(7);
    gf = yb_of(1) | yb_of(6);
    nst = 1; yv = 8'd0;
    if (st == 1) begin
      if (a && b) begin nst = 2; yv = ga; end
      else if (a) begin nst = 3; yv = gb; end
      else if (b) begin nst = 1; yv = 8'd0; end
      else begin nst = 4; yv = gc; end
    end else if (st == 2) begin
      if (a && b) begin nst = 2; yv = ga; end
      else if (b) begin nst = 5; yv = yb_of(1) | yb_of(2) | yb_of(4); end
      else if (a) begin nst = 3; yv = yb_of(3) | yb_of(4) | yb_of(6) | yb_of(8); end
      else begin nst = 4; yv = yb_of(3) | yb_of(4) | yb_of(5); end
    end else if (st == 3 || st == 6) begin
      if (st == 3 && c) begin nst = 6; yv = gb; end
      else if (st == 6 && !c) begin nst = 4; yv = gc; end
      else if (a && b) begin nst = 2; yv = ga; end
      else if (a) begin nst = st; yv = gb; end
      else if (b) begin nst = 5; yv = gd; end
      else begin nst = 4; yv = gc; end
    end else if (st == 4) begin
      if (c) begin nst = 7; yv = ge; end
      else if (a && b) begin nst = 2; yv = ga; end
      else if (a) begin nst = 3; yv = gb; end
      else begin nst = 4; yv = gc; end
    end else if (st == 5) begin
      if (e || (!a && !b)) begin nst = 4; yv = gc; end
      else if (a && b) begin nst = 8; yv = ga; end
      else if (b) begin nst = 5; yv = gd; end
      else begin nst = 9; yv = gb; end
      yv = yv | yb_of(8);
    end else if (st == 7) begin
      if (!c) begin nst = 4; yv = gc; end
      else if (a || d) begin nst = 10; yv = gf; end
      else begin nst = 7; yv = ge; end
    end else if (st == 8) begin
      nst = 2; yv = ga;
    end else if (st == 9) begin
      nst = 3; yv = gb;
    end else begin
      if (!c) begin nst = 4; yv = gc; end
      else if (a && b) begin nst = 2; yv = ga; end
      else if (a) begin nst = 6; yv = gb; end
      else begin nst = 1; yv = gf; end
    end
  endtask

  task automatic model_step(input int md, input logic [4:0] xv, input logic kv, input logic [7:0] kk,
                            input logic r, output logic [7:0] yv, output logic [7:0] cv, output logic mv);
    int nst;
    bit act;
    if (!r) begin
      m_st[md] = 1; m_cnt[md] = 0; yv = 8'd0;
    end else begin
      model_trans(m_st[md], xv, nst, yv);
      act = (m_st[md] == 1) && !(!xv[0] && xv[1]);
      if (act && m_cnt[md] >= LIMIT) begin
        yv = 8'd0;
        if (md == 1) nst = 1;
      end
      if (kv) m_cnt[md] = (kk == KEY) ? 0 : 255;
      else if (act && m_cnt[md] < 255) m_cnt[md] = m_cnt[md] + 1;
      m_st[md] = nst;
    end
    cv = 8'(m_cnt[md]);
    mv = (m_cnt[md] >= LIMIT);
  endtask

  task automatic step(input logic [4:0] xv, input logic kv, input logic [7:0] kk, input logic r);
    exp_t e;
    @(negedge clk);
    x = xv; key_vld = kv; key = kk; rst = r;
    model_step(0, xv, kv, kk, r, e.y0, e.c0, e.m0);
    model_step(1, xv, kv, kk, r, e.y1, e.c1, e.m1);
    sbq.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic route_s2_to_s1();
    step(mkx(0, 0, 0, 0, 0), 1'b0, 8'h00, 1'b1);
    step(mkx(0, 0, 1, 0, 0), 1'b0, 8'h00, 1'b1);
    step(mkx(0, 0, 1, 1, 0), 1'b0, 8'h00, 1'b1);
    step(mkx(0, 0, 1, 0, 0), 1'b0, 8'h00, 1'b1);
  endtask

  // Monitor: one expected entry per clock edge, sampled just after it.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("m0_y", ya, mon_e.y0);
      chk("m0_cnt", cnta, mon_e.c0);
      chk("m0_met", {7'd0, meta}, {7'd0, mon_e.m0});
      chk("m1_y", yb, mon_e.y1);
      chk("m1_cnt", cntb, mon_e.c1);
      chk("m1_met", {7'd0, metb}, {7'd0, mon_e.m1});
    end
  end

  initial begin
    logic [7:0] ga;
    logic [7:0] kk;
    ga = yb_of(1) | yb_of(3) | yb_of(4) | yb_of(5);
    rst = 1'b0; x = 5'd0; key_vld = 1'b0; key = 8'h00;
    m_st[0] = 1; m_st[1] = 1; m_cnt[0] = 0; m_cnt[1] = 0;

    step(5'd0, 1'b0, 8'h00, 1'b0);
    step(5'd0, 1'b0, 8'h00, 1'b0);
    settle();
    chk("rst_y", ya, 8'd0);
    chk("rst_cnt", cnta, 8'd0);
    chk("rst_met", {7'd0, meta}, 8'd0);

    // Five activations from s1; the fifth is over budget.
    for (int i = 0; i < 5; i++) begin
      step(mkx(1, 1, 0, 0, 0), 1'b0, 8'h00, 1'b1);
      settle();
      chk("act_y0", ya, (i == 4) ? 8'd0 : ga);
      chk("act_cnt0", cnta, 8'(i + 1));
      if (i == 4) begin
        chk("act5_met0", {7'd0, meta}, 8'd1);
        chk("lock_y1", yb, 8'd0);
        chk("lock_cnt1", cntb, 8'd5);
      end
      route_s2_to_s1();
      if (i == 0) chk("route_cnt0", cnta, 8'd1);
    end

    // Correct key clears, next activation serves C and goes to s4.
    step(mkx(0, 1, 0, 0, 0), 1'b1, KEY, 1'b1);
    settle();
    chk("key_ok_cnt", cnta, 8'd0);
    chk("key_ok_met", {7'd0, meta}, 8'd0);
    step(mkx(0, 0, 0, 0, 0), 1'b0, 8'h00, 1'b1);
    settle();
    chk("key_ok_act_y", ya, yb_of(1) | yb_of(2));
    chk("key_ok_act_cnt", cnta, 8'd1);

    // Wrong key saturates the counter.
    step(mkx(0, 1, 0, 0, 0), 1'b1, 8'h00, 1'b1);
    settle();
    chk("key_bad_cnt", cnta, 8'd255);
    chk("key_bad_met", {7'd0, meta}, 8'd1);
    step(mkx(0, 0, 1, 0, 0), 1'b0, 8'h00, 1'b1);
    step(mkx(0, 0, 1, 1, 0), 1'b0, 8'h00, 1'b1);
    step(mkx(0, 0, 1, 0, 0), 1'b0, 8'h00, 1'b1);
    step(mkx(1, 1, 0, 0, 0), 1'b0, 8'h00, 1'b1);
    settle();
    chk("sat_cnt", cnta, 8'd255);
    chk("sat_y", ya, 8'd0);

    // Reset in s5 with three activations counted.
    step(5'd0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(mkx(1, 1, 0, 0, 0), 1'b0, 8'h00, 1'b1);
      if (i < 2) route_s2_to_s1();
    end
    step(mkx(0, 1, 0, 0, 0), 1'b0, 8'h00, 1'b1);
    step(mkx(0, 1, 0, 0, 0), 1'b0, 8'h00, 1'b1);
    settle();
    chk("s5_cnt", cnta, 8'd3);
    step(mkx(0, 1, 0, 0, 0), 1'b0, 8'h00, 1'b0);
    settle();
    chk("midrst_y", ya, 8'd0);
    chk("midrst_cnt", cnta, 8'd0);
    chk("midrst_met", {7'd0, meta}, 8'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      kk = ($urandom_range(0, 1) == 0) ? KEY : 8'($urandom_range(0, 255));
      step(5'($urandom_range(0, 31)), ($urandom_range(0, 15) == 0), kk,
           ($urandom_range(0, 63) != 0));
    end

    settle();
    settle();
    chk("sb_drained", 8'(sbq.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
